// File: rtl/ext_bus_initiator.sv
// Single-access initiator for an async SRAM-style bus (cs/re/we, shared db).
// Every bus pin is a flop, loaded from the next-state so phases start on the edge.
module ext_bus_initiator #(
  parameter int SETUP_CYC     = 1,
  parameter int WR_STROBE_CYC = 3,
  parameter int RD_STROBE_CYC = 3,
  parameter int HOLD_CYC      = 1,
  parameter int TURN_CYC      = 1
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        cs,
  output logic        re,
  output logic        we,
  output logic [7:0]  ab,
  output logic [15:0] db_out,
  output logic        db_oe,
  input  logic [15:0] db_in
);
  localparam logic [3:0] SETUP_L = 4'(SETUP_CYC - 1);
  localparam logic [3:0] WR_L    = 4'(WR_STROBE_CYC - 1);
  localparam logic [3:0] RD_L    = 4'(RD_STROBE_CYC - 1);
  localparam logic [3:0] HOLD_L  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] TURN_L  = 4'(TURN_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

  state_t     state, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       wr_q;
  logic       accept, wr_d, in_bus, rd_sample;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  // the op bit must be visible on the accept edge, before wr_q is loaded
  assign wr_d      = accept ? req_write : wr_q;
  assign in_bus    = (nxt == SETUP) || (nxt == STROBE) || (nxt == HOLD);
  assign rd_sample = (state == STROBE) && (cnt == 4'd0) && !wr_q;

  always_comb begin
    nxt     = state;
    cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    case (state)
      IDLE:   if (accept) begin nxt = SETUP; cnt_nxt = SETUP_L; end
      SETUP:  if (cnt == 4'd0) begin nxt = STROBE; cnt_nxt = wr_q ? WR_L : RD_L; end
      STROBE: if (cnt == 4'd0) begin nxt = HOLD; cnt_nxt = HOLD_L; end
      HOLD:   if (cnt == 4'd0) begin nxt = TURN; cnt_nxt = TURN_L; end
      TURN:   if (cnt == 4'd0) begin nxt = IDLE; cnt_nxt = 4'd0; end
      default: begin nxt = IDLE; cnt_nxt = 4'd0; end
    endcase
  end

  always_ff @(posedge xclk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      cs        <= 1'b1;
      re        <= 1'b1;
      we        <= 1'b1;
      ab        <= 8'h00;
      db_out    <= 16'h0000;
      db_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wr_q   <= req_write;
        ab     <= req_addr;
        db_out <= req_wdata;
      end
      cs        <= !in_bus;
      we        <= !((nxt == STROBE) && wr_q);
      re        <= !((nxt == STROBE) && !wr_q);
      db_oe     <= in_bus && wr_d;
      rsp_valid <= (nxt == TURN) && (state != TURN);
      busy      <= (nxt != IDLE);
      if (rd_sample) rsp_rdata <= db_in;
    end
  end
endmodule

// File: tb/tb_ext_bus_initiator.sv
// Directed bench: default-parameter instance on an SRAM responder model,
// plus a stretched-timing instance for the long read.
module tb_ext_bus_initiator;
  logic        xclk = 1'b0;
  logic        reset;
  logic        req_valid_a, req_valid_b, req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;

  logic        req_ready_a, rsp_valid_a, busy_a, cs_a, re_a, we_a, db_oe_a;
  logic [15:0] rsp_rdata_a, db_out_a, db_in_a;
  logic [7:0]  ab_a;
  logic        req_ready_b, rsp_valid_b, busy_b, cs_b, re_b, we_b, db_oe_b;
  logic [15:0] rsp_rdata_b, db_out_b, db_in_b;
  logic [7:0]  ab_b;

  always #5 xclk = ~xclk;

  ext_bus_initiator dut_a (
    .xclk(xclk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .busy(busy_a),
    .cs(cs_a), .re(re_a), .we(we_a), .ab(ab_a), .db_out(db_out_a),
    .db_oe(db_oe_a), .db_in(db_in_a)
  );

  ext_bus_initiator #(.SETUP_CYC(2), .RD_STROBE_CYC(5), .HOLD_CYC(2), .TURN_CYC(3)) dut_b (
    .xclk(xclk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
    .cs(cs_b), .re(re_b), .we(we_b), .ab(ab_b), .db_out(db_out_b),
    .db_oe(db_oe_b), .db_in(db_in_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM responder: latches on the cycle we returns high with cs still low
  logic [15:0] mem [256];
  logic        pend;
  logic [7:0]  pa;
  logic [15:0] pd;
  logic        drv_mode;
  logic [15:0] drv_val;

  always @(posedge xclk) begin
    if (cs_a) pend <= 1'b0;
    else if (!we_a) begin pend <= 1'b1; pa <= ab_a; pd <= db_out_a; end
    else if (pend) begin mem[pa] <= pd; pend <= 1'b0; end
  end

  assign db_in_a = drv_mode ? drv_val : ((!cs_a && !re_a) ? mem[ab_a] : 16'h0000);

  int viol_a = 0;
  int viol_b = 0;
  always @(negedge xclk) begin
    if (!reset) begin
      if ((!re_a && db_oe_a) || (!re_a && !we_a) || (cs_a && (!re_a || !we_a))) viol_a++;
      if ((!re_b && db_oe_b) || (!re_b && !we_b) || (cs_b && (!re_b || !we_b))) viol_b++;
    end
  end

  logic [15:0] cs_t, re_t, we_t, oe_t, rv_t, rdy_t, bz_t, rd_at_rv;
  logic [23:0] bus_c3;

  // Issue one request at a negedge and sample n cycles (cycle 0 = accept cycle).
  task automatic run(input logic sel, input logic w, input logic [7:0] a,
                     input logic [15:0] d, input int n);
    req_write = w; req_addr = a; req_wdata = d;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    cs_t = '1; re_t = '1; we_t = '1; oe_t = '0; rv_t = '0; rdy_t = '0; bz_t = '0;
    rd_at_rv = 16'h0; bus_c3 = 24'h0;
    for (int c = 0; c < n; c++) begin
      if (drv_mode && c == 3) drv_val = 16'h1234;
      db_in_b = 16'hB000 + 16'(c);
      cs_t[c]  = sel ? cs_b : cs_a;
      re_t[c]  = sel ? re_b : re_a;
      we_t[c]  = sel ? we_b : we_a;
      oe_t[c]  = sel ? db_oe_b : db_oe_a;
      rv_t[c]  = sel ? rsp_valid_b : rsp_valid_a;
      rdy_t[c] = sel ? req_ready_b : req_ready_a;
      bz_t[c]  = sel ? busy_b : busy_a;
      if (sel ? rsp_valid_b : rsp_valid_a) rd_at_rv = sel ? rsp_rdata_b : rsp_rdata_a;
      if (c == 3) bus_c3 = sel ? {ab_b, db_out_b} : {ab_a, db_out_a};
      @(negedge xclk);
      if (c == 0) begin
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_addr = ~a; req_wdata = ~d; req_write = ~w;
      end
    end
  endtask

  logic [15:0] rdw, rdr;
  logic        rv_any;

  initial begin
    reset = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; req_write = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000; drv_mode = 1'b0; drv_val = 16'h0000;
    db_in_b = 16'h0000; pend = 1'b0; pa = 8'h00; pd = 16'h0000;
    repeat (3) @(negedge xclk);

    chk("rst_ctl", {cs_a, re_a, we_a, db_oe_a, rsp_valid_a, busy_a, req_ready_a}, 7'b1110000);
    chk("rst_bus", {ab_a, db_out_a}, 24'h0);
    chk("rst_rdata", rsp_rdata_a, 16'h0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", req_ready_a, 1'b1);

    // default write 0x3C <- 0xA55A
    run(1'b0, 1'b1, 8'h3C, 16'hA55A, 8);
    chk("wr_cs",    cs_t[7:0],  8'hC1);
    chk("wr_we",    we_t[7:0],  8'hE3);
    chk("wr_re",    re_t[7:0],  8'hFF);
    chk("wr_oe",    oe_t[7:0],  8'h3E);
    chk("wr_rv",    rv_t[7:0],  8'h40);
    chk("wr_ready", rdy_t[7:0], 8'h81);
    chk("wr_busy",  bz_t[7:0],  8'h7E);
    chk("wr_bus_stable", bus_c3, {8'h3C, 16'hA55A});
    chk("wr_rdata_kept", rsp_rdata_a, 16'h0);

    // default read 0x10, bus shows 0x1234 from cycle 3
    drv_mode = 1'b1; drv_val = 16'hDEAD;
    run(1'b0, 1'b0, 8'h10, 16'h0, 8);
    drv_mode = 1'b0;
    chk("rd_re",    re_t[7:0],  8'hE3);
    chk("rd_we",    we_t[7:0],  8'hFF);
    chk("rd_oe",    oe_t[7:0],  8'h00);
    chk("rd_cs",    cs_t[7:0],  8'hC1);
    chk("rd_rv",    rv_t[7:0],  8'h40);
    chk("rd_data",  rd_at_rv,   16'h1234);
    chk("rd_ready", rdy_t[7:0], 8'h81);

    // back-to-back write 0x05 <- 0xBEEF then read 0x05, req_valid held high
    req_write = 1'b1; req_addr = 8'h05; req_wdata = 16'hBEEF; req_valid_a = 1'b1;
    cs_t = '1; rv_t = '0; rdy_t = '0; rdw = 16'h0; rdr = 16'h0;
    for (int c = 0; c < 15; c++) begin
      cs_t[c] = cs_a; rv_t[c] = rsp_valid_a; rdy_t[c] = req_ready_a;
      if (c == 6) rdw = rsp_rdata_a;
      if (c == 13) rdr = rsp_rdata_a;
      @(negedge xclk);
      if (c == 0) req_write = 1'b0;
      if (c == 7) req_valid_a = 1'b0;
    end
    chk("b2b_cs",    cs_t,  16'hE0C1);
    chk("b2b_rv",    rv_t,  16'h2040);
    chk("b2b_ready", rdy_t, 16'h4081);
    chk("b2b_wr_rdata_kept", rdw, 16'h1234);
    chk("b2b_readback", rdr, 16'hBEEF);

    // reset during write strobe: preload 0x20, then abort an overwrite
    run(1'b0, 1'b1, 8'h20, 16'h1111, 8);
    req_write = 1'b1; req_addr = 8'h20; req_wdata = 16'h7777; req_valid_a = 1'b1;
    rv_any = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) reset = 1'b1;
      if (c == 4) begin
        chk("abort_bus", {cs_a, we_a, re_a, db_oe_a, busy_a}, 5'b11100);
        reset = 1'b0;
      end
      if (c == 5) chk("abort_ready", req_ready_a, 1'b1);
      if (rsp_valid_a) rv_any = 1'b1;
      @(negedge xclk);
      if (c == 0) req_valid_a = 1'b0;
    end
    chk("abort_no_rsp", rv_any, 1'b0);
    chk("abort_mem", mem[8'h20], 16'h1111);

    // stretched read on the second instance
    run(1'b1, 1'b0, 8'h42, 16'h0, 15);
    chk("long_cs",    cs_t,  16'hFC01);
    chk("long_re",    re_t,  16'hFF07);
    chk("long_oe",    oe_t,  16'h0000);
    chk("long_rv",    rv_t,  16'h0400);
    chk("long_ready", rdy_t, 16'h6001);
    chk("long_data",  rd_at_rv, 16'hB007);

    chk("protocol_a", viol_a, 0);
    chk("protocol_b", viol_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
